// File: rtl/cache_refill_unit.sv
// Cache line-fill engine: one line-aligned burst per miss, each beat written straight into the data RAM.
// Latency: address phase the cycle after accept, beats 1/cycle, refill_done LINE_WORDS+2 cycles after accept at best.
// Backpressure: arvalid/araddr held until arready; rready high for the whole data phase, rvalid gaps stall the beat counter.
//
// Ports:
//   clk, resetn                      single rising-edge clock, asynchronous active-low reset
//   miss_req/miss_addr/miss_ready    refill request from the pipeline, accepted only when idle
//   mem_ar*                          burst address channel (arlen fixed at LINE_WORDS-1)
//   mem_r*                           burst data channel
//   ram_en/ram_we/ram_addr/ram_din   data RAM write port, driven combinationally from the accepted beat
//   crit_valid/crit_data             registered copy of the missed word, one-cycle pulse
//   refill_done                      one-cycle pulse once the whole line is resident
//   proto_err                        sticky flag: mem_rlast disagreed with the beat count
module cache_refill_unit #(
   parameter int LEN_DATA   = 32,
   parameter int LEN_ADDR   = 10,
   parameter int LINE_WORDS = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  miss_req,
   input  logic [31:0]           miss_addr,
   output logic                  miss_ready,
   output logic                  mem_arvalid,
   output logic [31:0]           mem_araddr,
   output logic [7:0]            mem_arlen,
   input  logic                  mem_arready,
   input  logic                  mem_rvalid,
   input  logic [LEN_DATA-1:0]   mem_rdata,
   input  logic                  mem_rlast,
   output logic                  mem_rready,
   output logic                  ram_en,
   output logic [LEN_DATA/8-1:0] ram_we,
   output logic [LEN_ADDR-1:0]   ram_addr,
   output logic [LEN_DATA-1:0]   ram_din,
   output logic                  crit_valid,
   output logic [LEN_DATA-1:0]   crit_data,
   output logic                  refill_done,
   output logic                  proto_err
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = LEN_ADDR - OFF_W;
   localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_addr;
   logic [OFF_W-1:0]      r_cnt;
   logic                  r_crit_vld;
   logic [LEN_DATA-1:0]   r_crit_dat;
   logic                  r_proto_err;

   logic                  w_beat;
   logic                  w_last;
   logic                  w_crit_hit;
   logic                  w_unused;

   // Byte-offset bits of the request never reach the word-addressed RAM or the aligned burst.
   assign w_unused   = ^r_addr[1:0];

   assign w_last     = (r_cnt == LAST_CNT);
   assign w_crit_hit = (r_cnt == r_addr[2 +: OFF_W]);

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      miss_ready  = 1'b0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      w_beat      = 1'b0;
      refill_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            miss_ready = 1'b1;
            if (miss_req) begin
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            mem_arvalid = 1'b1;
            if (mem_arready) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            mem_rready = 1'b1;
            w_beat     = mem_rvalid;
            // Completion follows the beat count only; rlast is just cross-checked.
            if (mem_rvalid && w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            refill_done = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr      <= '0;
         r_cnt       <= '0;
         r_crit_vld  <= 1'b0;
         r_crit_dat  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_crit_vld <= w_beat && w_crit_hit;
         if (miss_ready && miss_req) begin
            r_addr <= miss_addr;
            r_cnt  <= '0;
         end
         if (w_beat) begin
            r_cnt <= r_cnt + OFF_W'(1);
            if (w_crit_hit) begin
               r_crit_dat <= mem_rdata;
            end
            if (mem_rlast != w_last) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

   assign mem_araddr = {r_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
   assign mem_arlen  = 8'(LINE_WORDS - 1);
   assign ram_en     = w_beat;
   assign ram_we     = {(LEN_DATA/8){w_beat}};
   assign ram_addr   = {r_addr[2+OFF_W +: IDX_W], r_cnt};
   assign ram_din    = mem_rdata;
   assign crit_valid = r_crit_vld;
   assign crit_data  = r_crit_dat;
   assign proto_err  = r_proto_err;

endmodule
